// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: FSM states, opcodes,
// AluControl values and datapath mux selects.
package alu_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_RST      = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC     = 4'd3,
        ST_MEM_ADDR = 4'd4,
        ST_MEM_RD   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_LOAD_WB  = 4'd7,
        ST_ALU_WB   = 4'd8,
        ST_BR_RES   = 4'd9,
        ST_JUMP     = 4'd10
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SRA = 4'b1101;

    localparam logic [1:0] SRCA_PC   = 2'd0;
    localparam logic [1:0] SRCA_RS1  = 2'd1;
    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    localparam logic RES_ALU      = 1'b0;
    localparam logic RES_MEM      = 1'b1;
    localparam logic ADR_PC       = 1'b0;
    localparam logic ADR_ALUOUT   = 1'b1;
    localparam logic PCSRC_RESULT = 1'b0;
    localparam logic PCSRC_ALUOUT = 1'b1;

    // Complete set of controller outputs, built per state and zero by default.
    typedef struct packed {
        logic [6:0] opcode;
        logic [3:0] alu_ctrl;
        logic [1:0] srca_sel;
        logic [1:0] srcb_sel;
        logic       pc_src;
        logic       pc_write;
        logic       ir_write;
        logic       reg_write;
        logic       result_src;
        logic       mem_req;
        logic       mem_we;
        logic       adr_src;
        logic       illegal_instr;
    } ctrl_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational AluControl decoder: maps opcode/funct3/funct7[5] to the ALU
// operation and flags encodings the controller cannot execute.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] alu_ctrl,
    output logic       legal
);

    always_comb begin
        // NOTE: every output gets a value before the case so no path infers a latch.
        alu_ctrl = ALU_ADD;
        legal    = 1'b1;
        case (opcode)
            OP_R, OP_I: begin
                case (funct3)
                    3'b000:  alu_ctrl = (opcode == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b101:  alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
                    default: alu_ctrl = {1'b0, funct3};
                endcase
            end
            OP_BRANCH: begin
                alu_ctrl = {1'b1, funct3};
                // funct3 010/011 have no RV32I branch meaning
                legal    = (funct3[2:1] != 2'b01);
            end
            OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: begin
                alu_ctrl = ALU_ADD;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the registered ALU, PC, register file and memory-port controls.
module multicycle_ctrl
    import alu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instr,
    input  logic        cond_chk,
    input  logic        mem_ready,
    output logic [6:0]  opcode_o,
    output logic [3:0]  alu_ctrl,
    output logic [1:0]  srca_sel,
    output logic [1:0]  srcb_sel,
    output logic        pc_src,
    output logic        pc_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        result_src,
    output logic        mem_req,
    output logic        mem_we,
    output logic        adr_src,
    output logic        illegal_instr,
    output logic [3:0]  state_o
);

    state_e     state_q, state_d;
    ctrl_t      ctrl;
    logic [6:0] opc;
    logic [3:0] dec_alu_ctrl;
    logic       dec_legal;
    logic       unused_instr_bits;

    assign opc               = instr[6:0];
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    alu_ctrl_decode u_decode (
        .opcode   (opc),
        .funct3   (instr[14:12]),
        .funct7_5 (instr[30]),
        .alu_ctrl (dec_alu_ctrl),
        .legal    (dec_legal)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
        if (!reset_n) state_q <= ST_RST;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ctrl    = '0;
        if (state_q != ST_RST) ctrl.opcode = opc;

        case (state_q)
            ST_RST: state_d = ST_FETCH;

            ST_FETCH: begin
                ctrl.opcode  = OP_R;
                ctrl.mem_req = 1'b1;
                ctrl.adr_src = ADR_PC;
                if (mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    state_d       = ST_DECODE;
                end
            end

            ST_DECODE: begin
                ctrl.opcode   = OP_R;
                ctrl.srca_sel = SRCA_PC;
                ctrl.srcb_sel = (opc == OP_BRANCH) ? SRCB_IMM : SRCB_FOUR;
                ctrl.alu_ctrl = ALU_ADD;
                state_d       = ST_EXEC;
            end

            ST_EXEC: begin
                if (!dec_legal) begin
                    // Illegal branches re-fetch from the same PC; other illegal opcodes skip ahead.
                    ctrl.illegal_instr = 1'b1;
                    ctrl.pc_write      = (opc != OP_BRANCH);
                    state_d            = ST_FETCH;
                end else begin
                    case (opc)
                        OP_R, OP_I: begin
                            ctrl.srca_sel = SRCA_RS1;
                            ctrl.srcb_sel = (opc == OP_R) ? SRCB_RS2 : SRCB_IMM;
                            ctrl.alu_ctrl = dec_alu_ctrl;
                            ctrl.pc_write = 1'b1;
                            state_d       = ST_ALU_WB;
                        end
                        OP_LUI: begin
                            ctrl.srcb_sel = SRCB_IMM;
                            ctrl.pc_write = 1'b1;
                            state_d       = ST_ALU_WB;
                        end
                        OP_AUIPC: begin
                            ctrl.srca_sel = SRCA_PC;
                            ctrl.srcb_sel = SRCB_IMM;
                            ctrl.pc_write = 1'b1;
                            state_d       = ST_ALU_WB;
                        end
                        OP_LOAD, OP_STORE: begin
                            ctrl.srca_sel = SRCA_RS1;
                            ctrl.srcb_sel = SRCB_IMM;
                            ctrl.alu_ctrl = ALU_ADD;
                            ctrl.pc_write = 1'b1;
                            state_d       = ST_MEM_ADDR;
                        end
                        OP_BRANCH: begin
                            ctrl.srca_sel = SRCA_RS1;
                            ctrl.srcb_sel = SRCB_RS2;
                            ctrl.alu_ctrl = dec_alu_ctrl;
                            state_d       = ST_BR_RES;
                        end
                        OP_JAL, OP_JALR: begin
                            // AluResult still holds PC+4 from DECODE for the link write.
                            ctrl.reg_write  = 1'b1;
                            ctrl.result_src = RES_ALU;
                            ctrl.srca_sel   = (opc == OP_JALR) ? SRCA_RS1 : SRCA_PC;
                            ctrl.srcb_sel   = SRCB_IMM;
                            state_d         = ST_JUMP;
                        end
                        default: begin
                            ctrl.illegal_instr = 1'b1;
                            ctrl.pc_write      = 1'b1;
                            state_d            = ST_FETCH;
                        end
                    endcase
                end
            end

            ST_MEM_ADDR: begin
                ctrl.srca_sel = SRCA_RS1;
                ctrl.srcb_sel = SRCB_IMM;
                ctrl.alu_ctrl = ALU_ADD;
                state_d       = (opc == OP_LOAD) ? ST_MEM_RD : ST_MEM_WR;
            end

            ST_MEM_RD, ST_MEM_WR: begin
                ctrl.srca_sel = SRCA_RS1;
                ctrl.srcb_sel = SRCB_IMM;
                ctrl.alu_ctrl = ALU_ADD;
                ctrl.mem_req  = 1'b1;
                ctrl.adr_src  = ADR_ALUOUT;
                ctrl.mem_we   = (state_q == ST_MEM_WR);
                if (mem_ready) state_d = (state_q == ST_MEM_RD) ? ST_LOAD_WB : ST_FETCH;
            end

            ST_LOAD_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_MEM;
                state_d         = ST_FETCH;
            end

            ST_ALU_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_ALU;
                state_d         = ST_FETCH;
            end

            ST_BR_RES: begin
                if (cond_chk) begin
                    ctrl.pc_write = 1'b1;
                    ctrl.pc_src   = PCSRC_ALUOUT;
                    state_d       = ST_FETCH;
                end else begin
                    ctrl.srca_sel = SRCA_PC;
                    ctrl.srcb_sel = SRCB_FOUR;
                    ctrl.alu_ctrl = ALU_ADD;
                    state_d       = ST_JUMP;
                end
            end

            ST_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PCSRC_RESULT;
                state_d       = ST_FETCH;
            end

            default: state_d = ST_RST;
        endcase
    end

    assign opcode_o      = ctrl.opcode;
    assign alu_ctrl      = ctrl.alu_ctrl;
    assign srca_sel      = ctrl.srca_sel;
    assign srcb_sel      = ctrl.srcb_sel;
    assign pc_src        = ctrl.pc_src;
    assign pc_write      = ctrl.pc_write;
    assign ir_write      = ctrl.ir_write;
    assign reg_write     = ctrl.reg_write;
    assign result_src    = ctrl.result_src;
    assign mem_req       = ctrl.mem_req;
    assign mem_we        = ctrl.mem_we;
    assign adr_src       = ctrl.adr_src;
    assign illegal_instr = ctrl.illegal_instr;
    assign state_o       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: runs hand-picked instructions through the
// FSM and compares per-state controls and cycle counts with hand-computed values.
module tb_multicycle_ctrl;

    localparam logic [3:0] S_RST      = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_EXEC     = 4'd3;
    localparam logic [3:0] S_MEM_RD   = 4'd5;
    localparam logic [3:0] S_MEM_WR   = 4'd6;
    localparam logic [3:0] S_LOAD_WB  = 4'd7;
    localparam logic [3:0] S_BR_RES   = 4'd9;
    localparam logic [3:0] S_JUMP     = 4'd10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] instr;
    logic        cond_chk, mem_ready;
    logic [6:0]  opcode_o;
    logic [3:0]  alu_ctrl, state_o;
    logic [1:0]  srca_sel, srcb_sel;
    logic        pc_src, pc_write, ir_write, reg_write, result_src;
    logic        mem_req, mem_we, adr_src, illegal_instr;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          cycles, pcw, ill, adr, rw, we;
        logic [15:0] seen;
        logic [6:0]  dec_op, ex_op;
        logic [1:0]  dec_srca, dec_srcb, ex_srca, ex_srcb, br_srcb;
        logic [3:0]  ex_alu;
        logic        br_pcw, br_pcsrc, jmp_pcw, jmp_pcsrc, wb_rs;
    } obs_t;

    multicycle_ctrl dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .instr         (instr),
        .cond_chk      (cond_chk),
        .mem_ready     (mem_ready),
        .opcode_o      (opcode_o),
        .alu_ctrl      (alu_ctrl),
        .srca_sel      (srca_sel),
        .srcb_sel      (srcb_sel),
        .pc_src        (pc_src),
        .pc_write      (pc_write),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .result_src    (result_src),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .adr_src       (adr_src),
        .illegal_instr (illegal_instr),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish before 100000");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Runs one instruction starting in FETCH; memory answers after mwait
    // stall cycles, and noise drives mem_ready high outside memory states.
    task automatic run_instr(input logic [31:0] ins, input logic cond, input int mwait,
                             input logic noise, output obs_t o);
        int w;
        o = '{default: 0};
        w = 0;
        instr = ins;
        cond_chk = cond;
        while (o.cycles < 40) begin
            case (state_o)
                S_FETCH: mem_ready = 1'b1;
                S_MEM_RD, S_MEM_WR: begin
                    mem_ready = (w == mwait);
                    if (w < mwait) w++;
                end
                default: mem_ready = noise;
            endcase
            #1;
            o.seen[state_o] = 1'b1;
            o.pcw += int'(pc_write);
            o.ill += int'(illegal_instr);
            o.adr += int'(adr_src);
            o.rw  += int'(reg_write);
            o.we  += int'(mem_we);
            if (state_o == S_DECODE) begin
                o.dec_op = opcode_o; o.dec_srca = srca_sel; o.dec_srcb = srcb_sel;
            end
            if (state_o == S_EXEC) begin
                o.ex_op = opcode_o; o.ex_alu = alu_ctrl;
                o.ex_srca = srca_sel; o.ex_srcb = srcb_sel;
            end
            if (state_o == S_BR_RES) begin
                o.br_pcw = pc_write; o.br_pcsrc = pc_src; o.br_srcb = srcb_sel;
            end
            if (state_o == S_JUMP) begin
                o.jmp_pcw = pc_write; o.jmp_pcsrc = pc_src;
            end
            if (state_o == S_LOAD_WB) o.wb_rs = result_src;
            o.cycles++;
            cyc();
            if (state_o == S_FETCH) break;
        end
        mem_ready = 1'b0;
    endtask

    initial begin
        obs_t o;
        instr = 32'h0; cond_chk = 1'b0; mem_ready = 1'b0;
        #1 reset_n = 1'b0;
        #2;
        check("rst_state", state_o, S_RST);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_opcode", opcode_o, 7'h00);
        check("rst_pc_write", pc_write, 1'b0);

        @(posedge clk); #2;
        reset_n = 1'b1;
        #1 check("rel_state", state_o, S_RST);
        cyc(); #1;
        check("fetch_state", state_o, S_FETCH);
        check("fetch_mem_req", mem_req, 1'b1);
        check("fetch_adr_src", adr_src, 1'b0);
        check("fetch_opcode", opcode_o, 7'h33);

        // ADD x3,x1,x2
        run_instr(32'h002081B3, 1'b0, 0, 1'b0, o);
        check("add_cycles", o.cycles, 4);
        check("add_states", o.seen, 16'h010E);
        check("add_dec_srca", o.dec_srca, 2'd0);
        check("add_dec_srcb", o.dec_srcb, 2'd2);
        check("add_ex_alu", o.ex_alu, 4'b0000);
        check("add_ex_srca", o.ex_srca, 2'd1);
        check("add_ex_srcb", o.ex_srcb, 2'd0);
        check("add_pc_writes", o.pcw, 1);
        check("add_reg_writes", o.rw, 1);
        check("add_ex_opcode", o.ex_op, 7'h33);

        // Same ADD with mem_ready asserted outside any memory access
        run_instr(32'h002081B3, 1'b0, 0, 1'b1, o);
        check("noise_cycles", o.cycles, 4);
        check("noise_states", o.seen, 16'h010E);

        run_instr(32'h402081B3, 1'b0, 0, 1'b0, o);
        check("sub_alu", o.ex_alu, 4'b1000);
        run_instr(32'h4030D093, 1'b0, 0, 1'b0, o);
        check("srai_alu", o.ex_alu, 4'b1101);
        check("srai_srcb", o.ex_srcb, 2'd1);
        check("srai_opcode", o.ex_op, 7'h13);
        run_instr(32'h00108093, 1'b0, 0, 1'b0, o);
        check("addi_alu", o.ex_alu, 4'b0000);
        run_instr(32'h40108093, 1'b0, 0, 1'b0, o);
        check("addi_f7_alu", o.ex_alu, 4'b0000);

        // LUI x1,0x12345
        run_instr(32'h123450B7, 1'b0, 0, 1'b0, o);
        check("lui_cycles", o.cycles, 4);
        check("lui_srcb", o.ex_srcb, 2'd1);
        check("lui_pc_writes", o.pcw, 1);

        // LW x2,0(x1) with three stall cycles in MEM_RD
        run_instr(32'h0000A103, 1'b0, 3, 1'b0, o);
        check("lw_cycles", o.cycles, 9);
        check("lw_adr_cycles", o.adr, 4);
        check("lw_result_src", o.wb_rs, 1'b1);
        check("lw_states", o.seen, 16'h00BE);
        check("lw_dec_opcode", o.dec_op, 7'h33);
        check("lw_pc_writes", o.pcw, 1);

        // SW x2,0(x1), zero-wait
        run_instr(32'h0020A023, 1'b0, 0, 1'b0, o);
        check("sw_cycles", o.cycles, 5);
        check("sw_we_cycles", o.we, 1);
        check("sw_states", o.seen, 16'h005E);
        check("sw_reg_writes", o.rw, 0);

        // BEQ x1,x2,+8 taken and not taken
        run_instr(32'h00208463, 1'b1, 0, 1'b0, o);
        check("beqt_cycles", o.cycles, 4);
        check("beqt_dec_srcb", o.dec_srcb, 2'd1);
        check("beqt_alu", o.ex_alu, 4'b1000);
        check("beqt_pc_write", o.br_pcw, 1'b1);
        check("beqt_pc_src", o.br_pcsrc, 1'b1);
        check("beqt_states", o.seen, 16'h020E);
        run_instr(32'h00208463, 1'b0, 0, 1'b0, o);
        check("beqn_cycles", o.cycles, 5);
        check("beqn_br_pc_write", o.br_pcw, 1'b0);
        check("beqn_br_srcb", o.br_srcb, 2'd2);
        check("beqn_jmp_pc_write", o.jmp_pcw, 1'b1);
        check("beqn_jmp_pc_src", o.jmp_pcsrc, 1'b0);
        check("beqn_pc_writes", o.pcw, 1);
        check("beqn_states", o.seen, 16'h060E);

        // JAL x1,8 and JALR x1,0(x2)
        run_instr(32'h008000EF, 1'b0, 0, 1'b0, o);
        check("jal_cycles", o.cycles, 4);
        check("jal_reg_writes", o.rw, 1);
        check("jal_srca", o.ex_srca, 2'd0);
        check("jal_srcb", o.ex_srcb, 2'd1);
        check("jal_pc_writes", o.pcw, 1);
        check("jal_jmp_pc_write", o.jmp_pcw, 1'b1);
        run_instr(32'h000100E7, 1'b0, 0, 1'b0, o);
        check("jalr_cycles", o.cycles, 4);
        check("jalr_srca", o.ex_srca, 2'd1);

        // Undecodable opcode, then branch with reserved funct3 010
        run_instr(32'h0000007F, 1'b0, 0, 1'b0, o);
        check("illop_cycles", o.cycles, 3);
        check("illop_pulses", o.ill, 1);
        check("illop_pc_writes", o.pcw, 1);
        check("illop_states", o.seen, 16'h000E);
        run_instr(32'h0020A463, 1'b0, 0, 1'b0, o);
        check("illbr_cycles", o.cycles, 3);
        check("illbr_pulses", o.ill, 1);
        check("illbr_pc_writes", o.pcw, 0);

        // Reset asserted while a load waits in MEM_RD
        instr = 32'h0000A103;
        for (int i = 0; i < 10 && state_o != S_MEM_RD; i++) begin
            mem_ready = (state_o == S_FETCH);
            cyc();
        end
        mem_ready = 1'b0;
        #1;
        check("mr_state", state_o, S_MEM_RD);
        check("mr_mem_req", mem_req, 1'b1);
        reset_n = 1'b0;
        #1;
        check("mr_rst_state", state_o, S_RST);
        check("mr_rst_mem_req", mem_req, 1'b0);
        check("mr_rst_adr_src", adr_src, 1'b0);
        check("mr_rst_srca", srca_sel, 2'd0);
        cyc();
        cyc();
        check("mr_hold_state", state_o, S_RST);
        reset_n = 1'b1;
        #1 check("mr_rel_state", state_o, S_RST);
        cyc(); #1;
        check("mr_fetch_state", state_o, S_FETCH);
        check("mr_fetch_mem_req", mem_req, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
